// File: rtl/rotate_seq_pkg.sv
// rotate_seq_pkg: shared state encoding and direction constants for rotate_sequencer
package rotate_seq_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, RUN} state_e;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/rot_left_core.sv
// rot_left_core: combinational log-stage left rotator
//   data_i : N-bit input pattern
//   amt_i  : rotate amount, valid for 0..N-1
//   data_o : data_i rotated left by amt_i
module rot_left_core #(
    parameter int N = 10,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  data_i,
    input  logic [AW-1:0] amt_i,
    output logic [N-1:0]  data_o
);
    logic [N-1:0] stg [AW+1];
    assign stg[0] = data_i;
    // Stage k rotates by 2**k; since 2**k < N for every k < AW, each stage is a
    // true rotation and the stages compose to a rotation by amt_i.
    for (genvar k = 0; k < AW; k++) begin : g_stage
        localparam int S = 2 ** k;
        assign stg[k+1] = amt_i[k] ? ((stg[k] << S) | (stg[k] >> (N - S))) : stg[k];
    end
    assign data_o = stg[AW];
endmodule

// File: rtl/rotate_sequencer.sv
// rotate_sequencer: steps a rotate amount over a loaded base pattern
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture pattern_in as base, amount := 0
//   pattern_in  : base pattern
//   run         : level, auto-step every TICK_DIV cycles when loaded
//   dir         : 0 rotate left (amount up), 1 rotate right (amount down)
//   step        : single-step pulse, honoured only when stopped
//   amt_out     : current amount, 0..N-1
//   pattern_out : registered rotl(base, amt_out)
//   wrap        : one-cycle pulse on N-1 -> 0 or 0 -> N-1
module rotate_sequencer
    import rotate_seq_pkg::*;
#(
    parameter int N = 10,
    parameter int TICK_DIV = 5_000_000,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [N-1:0]  pattern_in,
    input  logic          run,
    input  logic          dir,
    input  logic          step,
    output logic [AW-1:0] amt_out,
    output logic [N-1:0]  pattern_out,
    output logic          wrap
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e        state_q, state_d;
    logic [N-1:0]  base_q, base_d, pat_q, pat_d;
    logic [AW-1:0] amt_q, amt_d, amt_adv;
    logic [PW-1:0] pre_q, pre_d;
    logic          wrap_q, wrap_d, tick, adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            amt_q   <= '0;
            pre_q   <= '0;
            pat_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            amt_q   <= amt_d;
            pre_q   <= pre_d;
            pat_q   <= pat_d;
            wrap_q  <= wrap_d;
        end
    end

    // Once loaded, the run level alone selects HOLD vs RUN; a reload behaves the same.
    always_comb begin
        state_d = state_q;
        if (load || state_q != IDLE) state_d = run ? RUN : HOLD;
    end

    // Advance only when staying in the current mode: a run edge or a load
    // pre-empts any step or tick on the same clock.
    always_comb begin
        tick    = pre_q == PW'(TICK_DIV - 1);
        adv     = !load && ((state_q == HOLD && !run && step) || (state_q == RUN && run && tick));
        amt_adv = (dir == DIR_LEFT) ? ((amt_q == AW'(N - 1)) ? '0 : amt_q + AW'(1))
                                    : ((amt_q == '0) ? AW'(N - 1) : amt_q - AW'(1));
        base_d  = load ? pattern_in : base_q;
        amt_d   = load ? '0 : (adv ? amt_adv : amt_q);
        pre_d   = (!load && state_q == RUN && run && !tick) ? pre_q + PW'(1) : '0;
        wrap_d  = adv && ((dir == DIR_LEFT) ? (amt_q == AW'(N - 1)) : (amt_q == '0));
    end

    rot_left_core #(.N(N)) u_rot (
        .data_i (base_d),
        .amt_i  (amt_d),
        .data_o (pat_d)
    );

    assign amt_out     = amt_q;
    assign pattern_out = pat_q;
    assign wrap        = wrap_q;
endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer: directed self-checking bench for rotate_sequencer (N=10, TICK_DIV=4)
module tb_rotate_sequencer;
    import rotate_seq_pkg::*;
    localparam int N = 10;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset, load, run, dir, step;
    logic [N-1:0]  pattern_in;
    logic [AW-1:0] amt_out;
    logic [N-1:0]  pattern_out;
    logic          wrap;
    int            checks = 0;
    int            errors = 0;

    rotate_sequencer #(.N(N), .TICK_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .pattern_in  (pattern_in),
        .run         (run),
        .dir         (dir),
        .step        (step),
        .amt_out     (amt_out),
        .pattern_out (pattern_out),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input int a, input logic [N-1:0] p, input logic w);
        check({tag, "_amt"}, 32'(amt_out), 32'(a));
        check({tag, "_pat"}, 32'(pattern_out), 32'(p));
        check({tag, "_wrap"}, 32'(wrap), 32'(w));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; run = 1'b0; dir = 1'b0; step = 1'b0; pattern_in = '0;
        cyc(); cyc();
        outs("reset", 0, 10'h000, 1'b0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0;

        pattern_in = 10'h001; load = 1'b1;
        cyc();
        load = 1'b0;
        outs("load", 0, 10'h001, 1'b0);
        check("load_state", 32'(dut.state_q), 32'(HOLD));

        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            outs("step_l", i + 1, 10'(1 << (i + 1)), 1'b0);
            cyc();
        end
        outs("step_l_final", 3, 10'h008, 1'b0);

        load = 1'b1;
        cyc();
        load = 1'b0; dir = 1'b1; step = 1'b1;
        cyc();
        step = 1'b0;
        outs("step_r_wrap", 9, 10'h200, 1'b1);
        cyc();
        outs("step_r_after", 9, 10'h200, 1'b0);
        dir = 1'b0; step = 1'b1;
        cyc();
        step = 1'b0;
        outs("step_l_wrap", 0, 10'h001, 1'b1);
        cyc();
        outs("step_l_after", 0, 10'h001, 1'b0);

        load = 1'b1; run = 1'b1;
        cyc();
        load = 1'b0;
        outs("run_load", 0, 10'h001, 1'b0);
        check("run_state", 32'(dut.state_q), 32'(RUN));
        for (int k = 1; k <= 40; k++) begin
            cyc();
            outs($sformatf("run_k%0d", k), (k / 4) % 10, 10'(1 << ((k / 4) % 10)), k == 40);
        end

        step = 1'b1;
        cyc();
        step = 1'b0;
        outs("run_step_ign", 0, 10'h001, 1'b0);
        cyc(); cyc();
        run = 1'b0;
        cyc();
        outs("run_stop", 0, 10'h001, 1'b0);
        check("stop_state", 32'(dut.state_q), 32'(HOLD));

        for (int i = 0; i < 5; i++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            cyc();
        end
        outs("amt5", 5, 10'h020, 1'b0);
        pattern_in = 10'h155; load = 1'b1; step = 1'b1;
        cyc();
        load = 1'b0; step = 1'b0;
        outs("load_step", 0, 10'h155, 1'b0);
        cyc();
        outs("load_step_after", 0, 10'h155, 1'b0);

        pattern_in = 10'h001; load = 1'b1; run = 1'b1;
        cyc();
        load = 1'b0;
        repeat (24) cyc();
        outs("run_amt6", 6, 10'h040, 1'b0);
        reset = 1'b1;
        cyc();
        outs("reset_run", 0, 10'h000, 1'b0);
        check("reset_run_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0; step = 1'b1;
        cyc();
        step = 1'b0;
        repeat (5) cyc();
        outs("idle_ignore", 0, 10'h000, 1'b0);
        check("idle_state", 32'(dut.state_q), 32'(IDLE));

        pattern_in = 10'h003; load = 1'b1;
        cyc();
        load = 1'b0;
        outs("reload_run", 0, 10'h003, 1'b0);
        check("reload_state", 32'(dut.state_q), 32'(RUN));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
